// File: rtl/vram_writer.sv
// vram_writer: host register port that queues byte writes and drains them into VRAM slots left free by readout
module vram_writer #(
    parameter int ADDR_WIDTH = 13,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hostWrEn,
    input  logic [1:0]            hostRegSel,
    input  logic [7:0]            hostWrData,
    input  logic                  vramBusy,
    output logic                  vramWrEn,
    output logic [ADDR_WIDTH-1:0] vramWrAddr,
    output logic [7:0]            vramWrData,
    output logic                  fifoFull,
    output logic                  fifoEmpty,
    output logic [CNT_WIDTH-1:0]  fifoCount,
    output logic                  overflow
);
    localparam int PTR_WIDTH = CNT_WIDTH - 1;
    localparam int ENT_WIDTH = ADDR_WIDTH + 8;

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ENT_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  data_wr;
    logic                  push;
    logic                  pop;

    // Fullness is taken from the registered count, so a pop at the same edge never frees room for a push
    assign data_wr   = hostWrEn && hostRegSel == 2'd2;
    assign push      = data_wr && !fifoFull;
    assign pop       = !fifoEmpty && !vramBusy;
    assign fifoCount = count;
    assign fifoFull  = count == CNT_WIDTH'(FIFO_DEPTH);
    assign fifoEmpty = count == '0;

    // Address register: byte-wise host load, post-increment on every accepted data write
    always_ff @(posedge clk) begin
        if (rst)
            addr_reg <= '0;
        else if (hostWrEn && hostRegSel == 2'd0)
            addr_reg[7:0] <= hostWrData;
        else if (hostWrEn && hostRegSel == 2'd1)
            addr_reg[ADDR_WIDTH-1:8] <= hostWrData[ADDR_WIDTH-9:0];
        else if (push)
            addr_reg <= addr_reg + 1'b1;
    end

    // Entry storage needs no reset; the pointers define which slots are live
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {addr_reg, hostWrData};
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        end
    end

    // VRAM write port: one registered write per free slot, address/data hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            vramWrEn   <= 1'b0;
            vramWrAddr <= '0;
            vramWrData <= '0;
        end else if (pop) begin
            vramWrEn                 <= 1'b1;
            {vramWrAddr, vramWrData} <= mem[rd_ptr];
        end else begin
            vramWrEn <= 1'b0;
        end
    end

    // Sticky drop flag; a set takes priority over a clear
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (data_wr && fifoFull)
            overflow <= 1'b1;
        else if (hostWrEn && hostRegSel == 2'd3 && hostWrData[0])
            overflow <= 1'b0;
    end
endmodule

// File: tb/tb_vram_writer.sv
// tb_vram_writer: table vectors, corner sequences and random traffic against a queue-based model
module tb_vram_writer;
    localparam int AW    = 13;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hostWrEn = 1'b0;
    logic [1:0]    hostRegSel = 2'd0;
    logic [7:0]    hostWrData = 8'd0;
    logic          vramBusy = 1'b1;
    logic          vramWrEn;
    logic [AW-1:0] vramWrAddr;
    logic [7:0]    vramWrData;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [CW-1:0] fifoCount;
    logic          overflow;

    vram_writer #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .hostWrEn(hostWrEn), .hostRegSel(hostRegSel),
        .hostWrData(hostWrData), .vramBusy(vramBusy), .vramWrEn(vramWrEn),
        .vramWrAddr(vramWrAddr), .vramWrData(vramWrData), .fifoFull(fifoFull),
        .fifoEmpty(fifoEmpty), .fifoCount(fifoCount), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int d;
    } ent_t;

    typedef struct {
        bit       en;
        bit [1:0] sel;
        bit [7:0] d;
        bit       busy;
        bit       x_en;
        int       x_addr;
        int       x_data;
        int       x_cnt;
    } vec_t;

    ent_t q[$];
    int   m_addr, m_waddr, m_wdata;
    bit   m_ovf, m_en;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: VRAM writer semantics expressed over a queue, applied for one clock edge
    task automatic model(input bit r, input bit en, input bit [1:0] sel, input bit [7:0] d, input bit busy);
        bit   full;
        ent_t e;
        if (r) begin
            q.delete();
            m_addr = 0; m_ovf = 0; m_en = 0; m_waddr = 0; m_wdata = 0;
            return;
        end
        full = q.size() == DEPTH;
        if (q.size() > 0 && !busy) begin
            e = q.pop_front();
            m_en = 1; m_waddr = e.a; m_wdata = e.d;
        end else begin
            m_en = 0;
        end
        if (en) begin
            case (sel)
                2'd0: m_addr = (m_addr / 256) * 256 + d;
                2'd1: m_addr = (m_addr % 256) + ((d * 256) % (1 << AW));
                2'd2: if (full) m_ovf = 1;
                      else begin
                          e.a = m_addr; e.d = d;
                          q.push_back(e);
                          m_addr = (m_addr + 1) % (1 << AW);
                      end
                default: if (d[0]) m_ovf = 0;
            endcase
        end
    endtask

    task automatic step(input bit r, input bit en, input bit [1:0] sel, input bit [7:0] d, input bit busy);
        rst = r; hostWrEn = en; hostRegSel = sel; hostWrData = d; vramBusy = busy;
        model(r, en, sel, d, busy);
        @(posedge clk);
        #1;
        chk("wr_en", vramWrEn, m_en);
        chk("wr_addr", vramWrAddr, m_waddr);
        chk("wr_data", vramWrData, m_wdata);
        chk("count", fifoCount, q.size());
        chk("empty", fifoEmpty, q.size() == 0);
        chk("full", fifoFull, q.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic set_addr(input int a, input bit busy);
        step(0, 1, 0, 8'(a), busy);
        step(0, 1, 1, 8'(a >> 8), busy);
    endtask

    vec_t tbl[11];

    initial begin
        int n;
        tbl[0]  = '{1, 2'd0, 8'h34, 0, 0, 'h0000, 'h00, 0};
        tbl[1]  = '{1, 2'd1, 8'h12, 0, 0, 'h0000, 'h00, 0};
        tbl[2]  = '{1, 2'd2, 8'h41, 0, 0, 'h0000, 'h00, 1};
        tbl[3]  = '{0, 2'd0, 8'h00, 0, 1, 'h1234, 'h41, 0};
        tbl[4]  = '{0, 2'd0, 8'h00, 0, 0, 'h1234, 'h41, 0};
        tbl[5]  = '{1, 2'd0, 8'hFF, 0, 0, 'h1234, 'h41, 0};
        tbl[6]  = '{1, 2'd1, 8'h1F, 0, 0, 'h1234, 'h41, 0};
        tbl[7]  = '{1, 2'd2, 8'hAA, 0, 0, 'h1234, 'h41, 1};
        tbl[8]  = '{1, 2'd2, 8'hBB, 0, 1, 'h1FFF, 'hAA, 1};
        tbl[9]  = '{0, 2'd0, 8'h00, 0, 1, 'h0000, 'hBB, 0};
        tbl[10] = '{0, 2'd0, 8'h00, 0, 0, 'h0000, 'hBB, 0};

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("reset_empty", fifoEmpty, 1);
        chk("reset_en", vramWrEn, 0);

        // Basic write and address wrap from the vector table
        for (int i = 0; i < 11; i++) begin
            step(0, tbl[i].en, tbl[i].sel, tbl[i].d, tbl[i].busy);
            chk($sformatf("tbl%0d_en", i), vramWrEn, tbl[i].x_en);
            chk($sformatf("tbl%0d_addr", i), vramWrAddr, tbl[i].x_addr);
            chk($sformatf("tbl%0d_data", i), vramWrData, tbl[i].x_data);
            chk($sformatf("tbl%0d_cnt", i), fifoCount, tbl[i].x_cnt);
        end

        // Fill while busy, overflow on the 17th push, then drain in order
        set_addr('h0100, 1);
        for (int i = 0; i < 17; i++) begin
            step(0, 1, 2, 8'(i), 1);
            if (i == 15) chk("full_after_16", fifoFull, 1);
        end
        chk("ovf_after_17", overflow, 1);
        chk("cnt_after_17", fifoCount, 16);
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 0, 0, 0);
            chk("drain_en", vramWrEn, i < 16);
            if (i < 16) begin
                chk("drain_addr", vramWrAddr, 'h0100 + i);
                chk("drain_data", vramWrData, i);
            end
        end
        step(0, 1, 3, 8'h01, 0);
        chk("ovf_cleared", overflow, 0);

        // Push against a full FIFO at the same edge as a pop is still dropped
        for (int i = 0; i < 16; i++) step(0, 1, 2, 8'(i + 8'h80), 1);
        step(0, 1, 2, 8'hEE, 0);
        chk("fullpop_cnt", fifoCount, 15);
        chk("fullpop_ovf", overflow, 1);
        chk("fullpop_en", vramWrEn, 1);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0);
        step(0, 1, 3, 8'hFF, 0);

        // Alternating busy with four entries queued
        for (int i = 0; i < 4; i++) step(0, 1, 2, 8'(i + 8'h10), 1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, i % 2 == 1);
            if (vramWrEn) n++;
        end
        chk("toggle_writes", n, 4);
        chk("toggle_empty", fifoEmpty, 1);

        // Reset with entries queued and a write in flight
        for (int i = 0; i < 5; i++) step(0, 1, 2, 8'(i + 8'h20), 1);
        step(0, 0, 0, 0, 0);
        chk("pre_rst_en", vramWrEn, 1);
        step(1, 1, 2, 8'h77, 0);
        chk("rst_en", vramWrEn, 0);
        chk("rst_cnt", fifoCount, 0);
        chk("rst_empty", fifoEmpty, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk("post_rst_idle", vramWrEn, 0);
        end
        step(0, 1, 2, 8'h5A, 1);
        step(0, 0, 0, 0, 0);
        chk("rst_addr_zero", vramWrAddr, 0);
        chk("rst_addr_data", vramWrData, 'h5A);

        // Random traffic with alternating low/high readout pressure
        for (int i = 0; i < 600; i++) begin
            bit busy;
            busy = ((i / 60) % 2 == 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) < 6 ? 2'd2 : 2'($urandom_range(0, 3)),
                 8'($urandom), busy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
